// File: rtl/icache_refill_engine.sv
// icache_refill_engine: miss handler and line writer for a direct-mapped instruction cache.
//
// Fetches one 32-bit word per miss from backing memory and writes it, with its
// tag, into the cache set arrays through a one-cycle fill port.
// If memory stays silent for TIMEOUT cycles, the engine fills POISON and raises fill_error.
//
// Optional feature (macro NEXT_LINE_PREFETCH_EN): after each demand fill the
// engine also fetches and fills block address+1. That fill does not assert fill_done.
//
// Ports:
//   clock_i, reset_n_i       rising-edge clock, asynchronous active-low reset
//   miss_valid_i/_ready_o    miss handshake; miss_addr_i is the block address (PC[31:3])
//   mem_req_valid_o/_ready_i memory read request; mem_req_addr_o = {block, 3'b000}
//   mem_resp_valid_i/_data_i memory read response (ignored outside the wait states)
//   fill_valid_o             one-cycle write strobe with fill_set_o, fill_tag_o, fill_data_o
//   fill_done_o              demand miss serviced; fill_error_o marks a poison fill
//   fill_count_o             fills performed, saturating at 16'hFFFF
module icache_refill_engine #(
    parameter int          SETS    = 16,
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] POISON  = 32'hDEAD_BEEF
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic                    miss_valid_i,
    input  logic [28:0]             miss_addr_i,
    output logic                    miss_ready_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [31:0]             mem_req_addr_o,
    input  logic                    mem_resp_valid_i,
    input  logic [31:0]             mem_resp_data_i,
    output logic                    fill_valid_o,
    output logic [$clog2(SETS)-1:0] fill_set_o,
    output logic [28:0]             fill_tag_o,
    output logic [31:0]             fill_data_o,
    output logic                    fill_done_o,
    output logic                    fill_error_o,
    output logic [15:0]             fill_count_o
);
    localparam int SW = $clog2(SETS);
    localparam int TW = $clog2(TIMEOUT + 1);

    // REQ -> WAIT -> FILL are consecutive codes, as are PF_REQ -> PF_WAIT -> PF_FILL,
    // so both request paths advance with state_q + 1.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
`ifdef NEXT_LINE_PREFETCH_EN
    localparam logic [2:0] S_PF_REQ  = 3'd4;
    localparam logic [2:0] S_PF_WAIT = 3'd5;
    localparam logic [2:0] S_PF_FILL = 3'd6;
`endif

    logic [2:0]    state_q, state_d;
    logic [28:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic [15:0]   count_q, count_d;
    logic          in_req, in_wait, in_fill, timeout;

`ifdef NEXT_LINE_PREFETCH_EN
    assign in_req  = state_q == S_REQ  || state_q == S_PF_REQ;
    assign in_wait = state_q == S_WAIT || state_q == S_PF_WAIT;
    assign in_fill = state_q == S_FILL || state_q == S_PF_FILL;
`else
    assign in_req  = state_q == S_REQ;
    assign in_wait = state_q == S_WAIT;
    assign in_fill = state_q == S_FILL;
`endif

    assign timeout = timer_q == TW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        timer_d = timer_q;
        err_d   = err_q;
        count_d = count_q;
        if (state_q == S_IDLE) begin
            if (miss_valid_i) begin
                addr_d  = miss_addr_i;
                state_d = S_REQ;
            end
        end else if (in_req) begin
            if (mem_req_ready_i) begin
                state_d = state_q + 3'd1;
                timer_d = '0;
            end
        end else if (in_wait) begin
            timer_d = timer_q + TW'(1);
            // A response in the timeout cycle still wins over the poison value.
            if (mem_resp_valid_i || timeout) begin
                data_d  = mem_resp_valid_i ? mem_resp_data_i : POISON;
                err_d   = !mem_resp_valid_i;
                state_d = state_q + 3'd1;
                // Counted on entry to FILL so fill_count already includes the fill it accompanies.
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end
        end else if (in_fill) begin
`ifdef NEXT_LINE_PREFETCH_EN
            addr_d  = (state_q == S_FILL) ? addr_q + 29'd1 : addr_q;
            state_d = (state_q == S_FILL) ? S_PF_REQ : S_IDLE;
`else
            state_d = S_IDLE;
`endif
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign miss_ready_o    = state_q == S_IDLE;
    assign mem_req_valid_o = in_req;
    assign mem_req_addr_o  = {addr_q, 3'b000};
    assign fill_valid_o    = in_fill;
    assign fill_set_o      = addr_q[SW-1:0];
    assign fill_tag_o      = addr_q;
    assign fill_data_o     = data_q;
    assign fill_done_o     = state_q == S_FILL;
    assign fill_error_o    = in_fill && err_q;
    assign fill_count_o    = count_q;
endmodule

// File: tb/tb_icache_refill_engine.sv
// tb_icache_refill_engine: self-checking bench for icache_refill_engine.
//
// Stimulus comes from a table of directed misses, a few hand-written multi-cycle
// sequences and randomized misses.
// Expected fills come from a transaction-level model of the refill rules.
// NEXT_LINE_PREFETCH_EN, when defined for the build, adds the expected prefetch fill.
module tb_icache_refill_engine;
    localparam int          SETS    = 16;
    localparam int          TIMEOUT = 64;
    localparam logic [31:0] POISON  = 32'hDEAD_BEEF;
`ifdef NEXT_LINE_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic        miss_valid_i;
    logic [28:0] miss_addr_i;
    logic        miss_ready_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        fill_valid_o;
    logic [3:0]  fill_set_o;
    logic [28:0] fill_tag_o;
    logic [31:0] fill_data_o;
    logic        fill_done_o;
    logic        fill_error_o;
    logic [15:0] fill_count_o;

    icache_refill_engine dut (
        .clock_i          (clock_i),
        .reset_n_i        (reset_n_i),
        .miss_valid_i     (miss_valid_i),
        .miss_addr_i      (miss_addr_i),
        .miss_ready_o     (miss_ready_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .fill_valid_o     (fill_valid_o),
        .fill_set_o       (fill_set_o),
        .fill_tag_o       (fill_tag_o),
        .fill_data_o      (fill_data_o),
        .fill_done_o      (fill_done_o),
        .fill_error_o     (fill_error_o),
        .fill_count_o     (fill_count_o)
    );

    always #5 clock_i = ~clock_i;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;
    int exp_count = 0;

    always @(posedge clock_i) if (mem_req_valid_o && mem_req_ready_i) hs_cnt <= hs_cnt + 1;

    typedef struct {
        logic [28:0] addr;
        int          rdly;
        int          wdly;
        logic [31:0] data;
        logic [3:0]  e_set;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drives one miss from IDLE to IDLE.
    // rdly: request-stall cycles. wdly: WAIT cycle of the response (>= TIMEOUT means none).
    task automatic run_miss(input logic [28:0] a, input int rdly, input int wdly, input logic [31:0] d,
                            input logic [3:0] e_set, input logic [31:0] e_data, input logic e_err);
        int n;
        int h0;
        logic [28:0] an;
        h0 = hs_cnt;
        an = a + 29'd1;
        chk("idle_miss_ready", miss_ready_o, 1);
        miss_valid_i = 1'b1;
        miss_addr_i  = a;
        @(negedge clock_i);
        miss_valid_i = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            chk("req_valid", mem_req_valid_o, 1);
            chk("req_addr", mem_req_addr_o, {a, 3'b000});
            chk("busy_miss_ready", miss_ready_o, 0);
            mem_req_ready_i  = (i == rdly);
            mem_resp_valid_i = (i != rdly) && ($urandom % 2 == 1);
            mem_resp_data_i  = $urandom;
            @(negedge clock_i);
        end
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        n = (wdly < TIMEOUT) ? wdly + 1 : TIMEOUT;
        for (int k = 0; k < n; k++) begin
            chk("wait_no_fill", fill_valid_o, 0);
            chk("wait_no_req", mem_req_valid_o, 0);
            mem_resp_valid_i = (k == wdly);
            mem_resp_data_i  = (k == wdly) ? d : $urandom;
            @(negedge clock_i);
        end
        mem_resp_valid_i = 1'b0;
        exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 1;
        chk("fill_valid", fill_valid_o, 1);
        chk("fill_set", fill_set_o, e_set);
        chk("fill_tag", fill_tag_o, a);
        chk("fill_data", fill_data_o, e_data);
        chk("fill_done", fill_done_o, 1);
        chk("fill_error", fill_error_o, e_err);
        chk("fill_count", fill_count_o, exp_count);
        chk("fill_miss_ready", miss_ready_o, 0);
        if (PF == 1) begin
            @(negedge clock_i);
            chk("pf_req_valid", mem_req_valid_o, 1);
            chk("pf_req_addr", mem_req_addr_o, {an, 3'b000});
            chk("pf_miss_ready", miss_ready_o, 0);
            mem_req_ready_i = 1'b1;
            @(negedge clock_i);
            mem_req_ready_i  = 1'b0;
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = ~d;
            @(negedge clock_i);
            mem_resp_valid_i = 1'b0;
            exp_count = exp_count + 1;
            chk("pf_fill_valid", fill_valid_o, 1);
            chk("pf_fill_set", fill_set_o, 4'(an % SETS));
            chk("pf_fill_tag", fill_tag_o, an);
            chk("pf_fill_data", fill_data_o, ~d);
            chk("pf_fill_done", fill_done_o, 0);
            chk("pf_fill_count", fill_count_o, exp_count);
            chk("pf_miss_ready", miss_ready_o, 0);
        end
        @(negedge clock_i);
        chk("back_idle_ready", miss_ready_o, 1);
        chk("back_idle_fill", fill_valid_o, 0);
        chk("handshakes", hs_cnt - h0, 1 + PF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fills;
        int dones;
        logic [28:0] tags[2];
        logic early;
        vecs[0] = '{29'h20,       0, 0,   32'h910006D6, 4'd0,  32'h910006D6, 1'b0};
        vecs[1] = '{29'h21,       5, 1,   32'h0BADF00D, 4'd1,  32'h0BADF00D, 1'b0};
        vecs[2] = '{29'h25,       0, 200, 32'h11111111, 4'd5,  32'hDEADBEEF, 1'b1};
        vecs[3] = '{29'h25,       0, 63,  32'h22222222, 4'd5,  32'h22222222, 1'b0};
        vecs[4] = '{29'h25,       0, 62,  32'h33333333, 4'd5,  32'h33333333, 1'b0};
        vecs[5] = '{29'h1FFFFFFF, 1, 3,   32'h44444444, 4'd15, 32'h44444444, 1'b0};
        vecs[6] = '{29'h0,        0, 64,  32'h55555555, 4'd0,  32'hDEADBEEF, 1'b1};
        vecs[7] = '{29'h1234567,  2, 10,  32'hCAFEF00D, 4'd7,  32'hCAFEF00D, 1'b0};

        reset_n_i = 1'b0;
        miss_valid_i = 1'b0;
        miss_addr_i = '0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i = '0;
        repeat (3) @(negedge clock_i);
        chk("rst_miss_ready", miss_ready_o, 1);
        chk("rst_req_valid", mem_req_valid_o, 0);
        chk("rst_req_addr", mem_req_addr_o, 0);
        chk("rst_fill_valid", fill_valid_o, 0);
        chk("rst_fill_done", fill_done_o, 0);
        chk("rst_fill_error", fill_error_o, 0);
        chk("rst_fill_data", fill_data_o, 0);
        chk("rst_fill_count", fill_count_o, 0);
        reset_n_i = 1'b1;
        @(negedge clock_i);

        for (int v = 0; v < 8; v++)
            run_miss(vecs[v].addr, vecs[v].rdly, vecs[v].wdly, vecs[v].data,
                     vecs[v].e_set, vecs[v].e_data, vecs[v].e_err);

        // Reset while waiting for memory, then a late response.
        miss_valid_i = 1'b1;
        miss_addr_i  = 29'h33;
        @(negedge clock_i);
        miss_valid_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        @(negedge clock_i);
        mem_req_ready_i = 1'b0;
        repeat (3) @(negedge clock_i);
        #2 reset_n_i = 1'b0;
        #1;
        chk("async_rst_ready", miss_ready_o, 1);
        chk("async_rst_req", mem_req_valid_o, 0);
        chk("async_rst_count", fill_count_o, 0);
        exp_count = 0;
        @(negedge clock_i);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h77777777;
        @(negedge clock_i);
        mem_resp_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_no_fill", fill_valid_o, 0);
            chk("post_rst_no_done", fill_done_o, 0);
            chk("post_rst_no_req", mem_req_valid_o, 0);
            @(negedge clock_i);
        end
        chk("post_rst_count", fill_count_o, 0);
        chk("post_rst_ready", miss_ready_o, 1);

        // Second miss held high while the first is in flight; memory answers at once.
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h12345678;
        miss_valid_i = 1'b1;
        miss_addr_i  = 29'h29;
        @(negedge clock_i);
        miss_addr_i = 29'h2A;
        chk("held_first_addr", mem_req_addr_o, {29'h29, 3'b000});
        fills = 0;
        dones = 0;
        early = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fill_valid_o) begin
                fills++;
                chk("held_fill_data", fill_data_o, 32'h12345678);
            end
            if (fill_done_o) begin
                if (dones < 2) tags[dones] = fill_tag_o;
                dones++;
            end
            if (mem_req_valid_o && mem_req_addr_o == {29'h2A, 3'b000}) begin
                if (dones == 0) early = 1'b1;
                miss_valid_i = 1'b0;
            end
            @(negedge clock_i);
        end
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        miss_valid_i     = 1'b0;
        exp_count = exp_count + 2 * (1 + PF);
        chk("held_early_accept", early, 0);
        chk("held_dones", dones, 2);
        chk("held_fills", fills, 2 * (1 + PF));
        if (dones == 2) begin
            chk("held_tag0", tags[0], 29'h29);
            chk("held_tag1", tags[1], 29'h2A);
        end
        chk("held_count", fill_count_o, exp_count);
        chk("held_idle", miss_ready_o, 1);

        // Randomized misses against the transaction-level model.
        for (int t = 0; t < 24; t++) begin
            logic [28:0] a;
            logic [31:0] d;
            int rd;
            int wd;
            a  = 29'($urandom);
            d  = $urandom;
            rd = $urandom_range(0, 3);
            wd = ($urandom % 4 == 0) ? $urandom_range(60, 70) : $urandom_range(0, 5);
            run_miss(a, rd, wd, d, 4'(a % SETS), (wd < TIMEOUT) ? d : POISON, wd >= TIMEOUT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache_refill_engine.md
Name: icache_refill_engine

Overview:
- Miss handler and line writer for the 16-set, direct-mapped instruction cache.
- Accepts a block-address miss from the cache's lookup side and fetches the 32-bit word from backing memory over a valid/ready request channel plus a response channel.
- Writes the word and its tag back into the cache set arrays through a one-cycle fill port.
- Supplies the 0xDEAD_BEEF poison value only when memory times out, instead of on every miss.

Parameters:
- SETS, 16, number of direct-mapped sets; set index = block address mod SETS (power of two).
- TIMEOUT, 64, cycles spent in WAIT with no response before a poison fill.
- POISON, 32'hDEAD_BEEF, data written on timeout.

Ports:
- clock  input  1  main clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- miss_valid  input  1  cache requests a line fill.
- miss_addr  input  29  block address (PC[31:3]) of the missing line.
- miss_ready  output  1  engine can accept a miss (high only in IDLE).
- mem_req_valid  output  1  read request to backing memory.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  32  byte address = {block, 3'b000}.
- mem_resp_valid  input  1  read data valid.
- mem_resp_data  input  32  read data.
- fill_valid  output  1  one-cycle write strobe to the cache arrays.
- fill_set  output  log2(SETS)  set index written.
- fill_tag  output  29  block address stored in setAddress.
- fill_data  output  32  word stored in setData.
- fill_done  output  1  one-cycle pulse; the demand miss has been serviced.
- fill_error  output  1  one-cycle pulse, coincident with a poison fill.
- fill_count  output  16  number of fills performed, saturating at 16'hFFFF.

Behaviour:
- Reset state, entered asynchronously:
  - state IDLE.
  - All outputs 0 except miss_ready, which is 1.
  - Latched address, data and timer cleared.
- States are IDLE, REQ, WAIT, FILL; PF_REQ, PF_WAIT and PF_FILL exist only with the optional feature.
- IDLE:
  - miss_ready=1.
  - On miss_valid&&miss_ready, latch miss_addr and go to REQ.
- REQ:
  - mem_req_valid=1, with mem_req_addr stable until handshake.
  - On mem_req_ready, go to WAIT and clear the timer.
- WAIT:
  - Timer increments every cycle.
  - On mem_resp_valid, latch mem_resp_data and go to FILL.
  - If the timer equals TIMEOUT-1 with no response, latch POISON, flag an error and go to FILL.
  - A response in the same cycle as the timeout wins: no error is flagged.
- FILL, one cycle:
  - fill_valid=1, fill_set=addr[log2(SETS)-1:0], fill_tag=addr, fill_data=latched word.
  - fill_done=1, and fill_error=1 if the error is flagged.
  - fill_count increments unless already 16'hFFFF.
  - Next state IDLE.
- Minimum latency with zero-wait memory:
  - Handshake in cycle 0, REQ in cycle 1, response in cycle 2, fill_valid in cycle 3.
  - A new miss can be accepted in cycle 4.
- mem_resp_valid outside WAIT/PF_WAIT is ignored.
- miss_valid while busy is not accepted. The requester holds miss_addr stable.
- fill_valid is the only write strobe; all fill_* values are don't-care when it is low but are driven registered.
- Reset mid-operation:
  - The transaction is abandoned with no fill and no fill_done.
  - A response arriving after reset is released is ignored, because the state is IDLE.
  - fill_count returns to 0.

Optional Feature:
- Macro: NEXT_LINE_PREFETCH_EN.
- With the macro, after a demand FILL the engine goes to PF_REQ for block address+1, modulo 2^29 so that 0x1FFFFFFF wraps to 0.
  - PF_REQ, PF_WAIT and PF_FILL behave as REQ, WAIT and FILL, including timeout and poison.
  - The prefetch fill asserts fill_valid and increments fill_count, but does not assert fill_done.
  - miss_ready stays 0 until the prefetch FILL completes.
- Without the macro, the PF_* states are absent and FILL always returns to IDLE.

Test Plan:
- Miss on 0x00000020 with mem_req_ready=1 and a response of 32'h910006D6 in the next cycle -> mem_req_addr=0x00000100, then fill_valid in cycle 3 with set 0, tag 0x20, data 0x910006D6, and fill_done=1, fill_error=0, fill_count=1.
- Miss on 0x21 with mem_req_ready low for 5 cycles -> mem_req_valid stays high and mem_req_addr stays 0x00000108 throughout; exactly one request handshake occurs.
- Miss on 0x25 with no response -> fill exactly TIMEOUT(64) cycles after entering WAIT, with set 5, data 32'hDEADBEEF, fill_error=1 and fill_done=1. A second run with the response in the final timeout cycle -> real data and fill_error=0.
- reset_n driven low while in WAIT, then a response arriving after release -> no fill_valid, fill_count=0, miss_ready=1.
- Second miss 0x2A held high during the first miss -> accepted only once back in IDLE; two fills total, and fill_count=2.
- With NEXT_LINE_PREFETCH_EN, miss on 0x1FFFFFFF -> demand fill to set 15 with fill_done, then a prefetch request to address 0x00000000 and a fill to set 0 with no fill_done; miss_ready low until then.
